toggle_sequencer: RTL
=====================

# toggle_sequencer

Upstream stimulus stage for the T latch: accepts a request for N toggles and drives the latch's `t`/`en` inputs as a train of single-cycle toggle pulses separated by a programmable gap. The latch output is fed back on `q_in` and checked after every pulse. `busy`/`done` hand the result to the controlling logic. The block also flags any toggle the latch failed to perform.

## Interface
- `CNT_W`, 8: width of the toggle count and of `remaining`.
- `GAP_W`, 4: width of the inter-pulse gap field.

- `clk`  in  1  single system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset; one clock; reset is asynchronous and active-high.
- `start`  in  1  request strobe; sampled only in IDLE.
- `count`  in  CNT_W  number of toggles to issue; captured when `start` is accepted.
- `gap`  in  GAP_W  idle cycles after each pulse; captured when `start` is accepted; 0 is treated as 1.
- `q_in`  in  1  latch output feedback.
- `t`  out  1  toggle input to the latch.
- `en`  out  1  enable to the latch.
- `busy`  out  1  high in PULSE, GAP and DONE.
- `done`  out  1  one-cycle completion pulse.
- `remaining`  out  CNT_W  pulses not yet issued.
- `mismatch`  out  1  sticky error: `q_in` did not toggle as expected.

## Operation
- **States:** IDLE, PULSE, GAP, DONE. All state is registered.
- **Reset value of every output:** 0 for `t`, `en`, `busy`, `done`, `remaining` and `mismatch`. FSM resets to IDLE and internal counters to 0.
- **IDLE, `start`=1:**
  - capture `count` into `remaining` and G = max(`gap`,1) into the gap reload;
  - capture `expected` = `q_in`;
  - clear `mismatch`;
  - go to PULSE, or go directly to DONE if `count`=0.
- **IDLE, `start`=0:** stay in IDLE.
- **PULSE (exactly 1 cycle):**
  - `t`=1, `en`=1;
  - at the edge ending the cycle: `remaining` -= 1, `expected` inverts, gap counter loads G;
  - go to GAP.
- **GAP (G cycles):**
  - `t`=0, `en`=0; gap counter decrements each cycle.
  - On the last GAP cycle edge, compare `q_in` with `expected`; if they differ, set `mismatch`=1. It stays set until reset or the next accepted `start`.
  - Then go to DONE if `remaining`=0, otherwise go to PULSE.
- **DONE (1 cycle):** `done`=1, `busy`=1; then go to IDLE.
- **`start` outside IDLE:** ignored, including during DONE.
- **`remaining` arithmetic:** unsigned CNT_W. It never decrements below 0, because PULSE is entered only with `remaining` ≥ 1.
- **Full-scale `count`:** `count` = 2^CNT_W−1 issues that many pulses with no wrap.
- **Checking after mismatch:** remaining pulses are still issued and checked. `expected` follows the commanded sequence, not `q_in`.
- **Reset asserted mid-operation:** all outputs go to 0 immediately, without waiting for a clock edge. The FSM returns to IDLE and the partial sequence is discarded.

## Timing
- Acceptance edge = cycle 0. The first PULSE occupies cycle 1.
- Pulse k (k = 0..N−1) occupies cycle 1 + k·(1+G).
- `done` is high in cycle N·(1+G)+1. With `count`=0, `done` is high in cycle 1 and `en` never rises.
- Earliest next acceptance is in cycle N·(1+G)+2 (the first IDLE cycle).
- `remaining` updates on the edge ending each PULSE. It reads N during the first PULSE and 0 during DONE.
- `mismatch` rises no earlier than the edge ending the last GAP cycle of the failing pulse.
- `t` and `en` are register outputs. They never go high outside PULSE.

## Test plan
- **Reset values:** assert `reset` for 10 ns with `clk` running → all outputs 0.
- **Nominal run:** release reset, then `count`=3, `gap`=2, with a behavioral T latch on `q_in` → `en`=`t`=1 in cycles 1, 4, 7; `done` in cycle 10; `mismatch`=0; `q_in` ends inverted.
- **Zero count:** `count`=0 → `done` in cycle 1; `en` stays 0; `busy` high in cycle 1 only.
- **Gap of zero, ignored start:** `gap`=0, `count`=2 → pulses in cycles 1 and 3, `done` in cycle 5. A `start` driven in cycles 2 and 5 is ignored.
- **Stuck latch:** hold `q_in`=0, `count`=2, `gap`=1 → `mismatch` goes to 1 after cycle 2. It stays at 1 through `done` in cycle 5 and clears on the next `start`.
- **Reset mid-operation:** `count`=5, `gap`=3; assert `reset` asynchronously in cycle 6 → outputs 0 immediately. After release, a new `start` with `count`=1 completes with `done` 5 cycles after acceptance.

Source files
------------

// File: rtl/toggle_sequencer.sv
// Drives a T latch with a train of single-cycle toggle pulses separated by a
// programmable gap, checking the fed-back latch output after every pulse.
module toggle_sequencer #(
   parameter int CNT_W = 8,
   parameter int GAP_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [CNT_W-1:0] count,
   input  logic [GAP_W-1:0] gap,
   input  logic             q_in,
   output logic             t,
   output logic             en,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] remaining,
   output logic             mismatch
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_PULSE,
      S_GAP,
      S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] rem_q, rem_d;
   logic [GAP_W-1:0] gload_q, gload_d;
   logic [GAP_W-1:0] gcnt_q, gcnt_d;
   logic             exp_q, exp_d;
   logic             mis_q, mis_d;
   logic             t_q, t_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [GAP_W-1:0] gap_eff;

   // A zero gap would leave no cycle to sample q_in, so it acts as one.
   assign gap_eff = (gap == '0) ? GAP_W'(1) : gap;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         rem_q   <= '0;
         gload_q <= '0;
         gcnt_q  <= '0;
         exp_q   <= 1'b0;
         mis_q   <= 1'b0;
         t_q     <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         gload_q <= gload_d;
         gcnt_q  <= gcnt_d;
         exp_q   <= exp_d;
         mis_q   <= mis_d;
         t_q     <= t_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      gload_d = gload_q;
      gcnt_d  = gcnt_q;
      exp_d   = exp_q;
      mis_d   = mis_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               rem_d   = count;
               gload_d = gap_eff;
               exp_d   = q_in;
               mis_d   = 1'b0;
               state_d = (count == '0) ? S_DONE : S_PULSE;
            end
         end
         S_PULSE: begin
            rem_d   = rem_q - CNT_W'(1);
            exp_d   = ~exp_q;
            gcnt_d  = gload_q;
            state_d = S_GAP;
         end
         S_GAP: begin
            gcnt_d = gcnt_q - GAP_W'(1);
            if (gcnt_q == GAP_W'(1)) begin
               if (q_in != exp_q) begin
                  mis_d = 1'b1;
               end
               state_d = (rem_q == '0) ? S_DONE : S_PULSE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Outputs are decoded from the next state so they leave the flops clean.
   always_comb begin
      t_d    = (state_d == S_PULSE);
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
   end

   assign t         = t_q;
   assign en        = t_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign remaining = rem_q;
   assign mismatch  = mis_q;

endmodule
